// File: rtl/kyber_seq_pkg.sv
// Shared types and sizing for the polynomial accumulate sequencer.
package kyber_seq_pkg;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 16;
  localparam int POLY_W  = KYBER_N * COEF_W;
  localparam int MAX_OPS = 5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  // Operand count must select at least one mux port and no more than exist.
  function automatic logic ops_legal(input logic [2:0] n, input int max_ops);
    return (n != 3'd0) && (int'(n) <= max_ops);
  endfunction
endpackage

// File: rtl/poly_acc_seq_if.sv
// Control, mux and adder handshake bundle between the sequencer and its parent.
interface poly_acc_seq_if #(parameter int POLY_W = kyber_seq_pkg::POLY_W);
  logic              start;
  logic [2:0]        num_ops;
  logic              abort;
  logic [2:0]        mux_sel;
  logic [POLY_W-1:0] mux_out;
  logic [POLY_W-1:0] add_a;
  logic [POLY_W-1:0] add_b;
  logic [POLY_W-1:0] add_sum;
  logic              busy;
  logic              done;
  logic              err;
  logic [POLY_W-1:0] result;

  modport slave (
    input  start, num_ops, abort, mux_out, add_sum,
    output mux_sel, add_a, add_b, busy, done, err, result
  );

  modport master (
    output start, num_ops, abort, mux_out, add_sum,
    input  mux_sel, add_a, add_b, busy, done, err, result
  );
endinterface

// File: rtl/poly_acc_seq.sv
// Sequences an external operand mux and adder to sum operands 0..num_ops-1
// into one polynomial; all control outputs are registered.
module poly_acc_seq #(
  parameter int POLY_W  = kyber_seq_pkg::POLY_W,
  parameter int MAX_OPS = kyber_seq_pkg::MAX_OPS
) (
  input  logic          clk,
  input  logic          rst_n,
  poly_acc_seq_if.slave bus
);
  import kyber_seq_pkg::*;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic [2:0]        nops_q;
  logic [POLY_W-1:0] acc_q;
  logic [POLY_W-1:0] result_q;
  logic [2:0]        mux_sel_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Adder operands are pure wiring; the adder owns carries and reduction.
  assign bus.add_a   = acc_q;
  assign bus.add_b   = bus.mux_out;
  assign bus.mux_sel = mux_sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      nops_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      mux_sel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort outranks start, so a simultaneous request is dropped.
          if (!bus.abort && bus.start) begin
            if (ops_legal(bus.num_ops, MAX_OPS)) begin
              nops_q    <= bus.num_ops;
              idx_q     <= '0;
              mux_sel_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            mux_sel_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            acc_q <= bus.mux_out;
            if (nops_q == 3'd1) begin
              mux_sel_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q     <= 3'd1;
              mux_sel_q <= 3'd1;
              state_q   <= S_ADD;
            end
          end
        end
        S_ADD: begin
          if (bus.abort) begin
            mux_sel_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            acc_q <= bus.add_sum;
            if (idx_q == nops_q - 3'd1) begin
              mux_sel_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              mux_sel_q <= idx_q + 3'd1;
            end
          end
        end
        S_DONE: begin
          // Commit happens here regardless of abort; done is already high.
          result_q <= acc_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mux_sel_q <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_acc_seq.sv
// Directed bench: models the 5:1 mux and a per-coefficient 16-bit adder.
module tb_poly_acc_seq;
  import kyber_seq_pkg::*;
  localparam int PW = POLY_W;
  localparam int NC = PW / 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_acc_seq_if #(.POLY_W(PW)) bus();
  poly_acc_seq #(.POLY_W(PW), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  logic [PW-1:0] in_poly [5];
  int total = 0;
  int bad   = 0;

  always_comb begin
    case (bus.mux_sel)
      3'd0:    bus.mux_out = in_poly[0];
      3'd1:    bus.mux_out = in_poly[1];
      3'd2:    bus.mux_out = in_poly[2];
      3'd3:    bus.mux_out = in_poly[3];
      3'd4:    bus.mux_out = in_poly[4];
      default: bus.mux_out = '0;
    endcase
  end

  always_comb begin
    bus.add_sum = '0;
    for (int i = 0; i < NC; i++)
      bus.add_sum[i*16 +: 16] = bus.add_a[i*16 +: 16] + bus.add_b[i*16 +: 16];
  end

  function automatic logic [PW-1:0] rep(input logic [15:0] c);
    return {NC{c}};
  endfunction

  function automatic int first_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    for (int i = 0; i < NC; i++)
      if (a[i*16 +: 16] !== b[i*16 +: 16]) return i;
    return 0;
  endfunction

  task automatic set_ramp();
    for (int i = 0; i < 5; i++) in_poly[i] = rep(16'(i + 1));
  endtask

  // Stimulus only: issue start, run maxc cycles, report first done cycle and count.
  task automatic run_op(input logic [2:0] n, input int maxc, output int dcyc, output int ndone);
    dcyc = 0; ndone = 0;
    @(negedge clk); bus.start = 1'b1; bus.num_ops = n;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1; bus.start = 1'b0;
      if (bus.done) begin ndone++; if (dcyc == 0) dcyc = c; end
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    total++; if (bus.mux_sel !== 3'd0) begin bad++; $display("FAIL reset_mux_sel got=%0d exp=0", bus.mux_sel); end
    total++; if (bus.result !== '0) begin bad++; $display("FAIL reset_result coef0 got=%h exp=0", bus.result[15:0]); end
    total++; if (bus.add_a !== '0) begin bad++; $display("FAIL reset_acc coef0 got=%h exp=0", bus.add_a[15:0]); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sum5();
    int exp_sel [7] = '{0, 0, 1, 2, 3, 4, 0};
    int dcyc = 0, ndone = 0, k;
    logic [PW-1:0] exp_r;
    set_ramp();
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd5;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1; bus.start = 1'b0;
      if (c <= 6) begin
        total++;
        if (int'(bus.mux_sel) != exp_sel[c]) begin
          bad++; $display("FAIL sum5_mux_sel cycle=%0d got=%0d exp=%0d", c, bus.mux_sel, exp_sel[c]);
        end
      end
      if (bus.done) begin ndone++; if (dcyc == 0) dcyc = c; end
    end
    total++; if (dcyc != 6) begin bad++; $display("FAIL sum5_done_cycle got=%0d exp=6", dcyc); end
    total++; if (ndone != 1) begin bad++; $display("FAIL sum5_done_count got=%0d exp=1", ndone); end
    exp_r = rep(16'd15);
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL sum5_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sum5_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    int dcyc, ndone, k;
    logic [PW-1:0] exp_r;
    in_poly[0] = rep(16'h1234);
    run_op(3'd1, 6, dcyc, ndone);
    exp_r = rep(16'h1234);
    total++; if (dcyc != 2) begin bad++; $display("FAIL single_done_cycle got=%0d exp=2", dcyc); end
    total++; if (ndone != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL single_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  task automatic test_err();
    logic [2:0] bad_n [2] = '{3'd0, 3'd6};
    int errs, busys, k;
    logic [PW-1:0] exp_r;
    for (int t = 0; t < 2; t++) begin
      errs = 0; busys = 0;
      @(negedge clk); bus.start = 1'b1; bus.num_ops = bad_n[t];
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1; bus.start = 1'b0;
        if (bus.err) errs++;
        if (bus.busy) busys++;
      end
      total++; if (errs != 1) begin bad++; $display("FAIL err_pulse n=%0d got=%0d exp=1", bad_n[t], errs); end
      total++; if (busys != 0) begin bad++; $display("FAIL err_busy n=%0d got=%0d exp=0", bad_n[t], busys); end
    end
    exp_r = rep(16'h1234);
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL err_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  task automatic test_ignore_abort();
    int dcyc = 0, ndone = 0, k;
    logic [PW-1:0] exp_r;
    set_ramp();
    exp_r = rep(16'd10);
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd4;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1; bus.start = 1'b0;
      if (bus.done) begin ndone++; if (dcyc == 0) dcyc = c; end
      if (c == 3) begin bus.start = 1'b1; bus.num_ops = 3'd1; end
    end
    total++; if (dcyc != 5) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=5", dcyc); end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL ignore_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
    ndone = 0;
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd4;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;
      if (bus.done) ndone++;
      if (c == 3) begin
        total++; if (bus.mux_sel !== 3'd2) begin bad++; $display("FAIL abort_at_idx2 got=%0d exp=2", bus.mux_sel); end
        bus.abort = 1'b1;
      end
      if (c == 4) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      end
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL abort_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  task automatic test_abort_idle();
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd2; bus.abort = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b exp=0", bus.busy); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL abort_idle_err got=%b exp=0", bus.err); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy2 got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abort_done();
    int dcyc = 0, ndone = 0, k;
    logic [PW-1:0] exp_r;
    exp_r = rep(16'd3);
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd2;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;
      if (bus.done) begin ndone++; if (dcyc == 0) dcyc = c; end
      if (c == 3) bus.abort = 1'b1;
    end
    total++; if (dcyc != 3 || ndone != 1) begin bad++; $display("FAIL abort_done_pulse cycle=%0d count=%0d exp cycle=3 count=1", dcyc, ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL abort_done_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  task automatic test_reset_mid();
    int dcyc, ndone, k;
    logic [PW-1:0] exp_r;
    @(negedge clk); bus.start = 1'b1; bus.num_ops = 3'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.mux_sel !== 3'd0) begin bad++; $display("FAIL rstmid_mux_sel got=%0d exp=0", bus.mux_sel); end
    total++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL rstmid_pulses got=%b%b exp=00", bus.done, bus.err); end
    total++; if (bus.result !== '0) begin bad++; $display("FAIL rstmid_result coef0 got=%h exp=0", bus.result[15:0]); end
    total++; if (bus.add_a !== '0) begin bad++; $display("FAIL rstmid_acc coef0 got=%h exp=0", bus.add_a[15:0]); end
    @(negedge clk); rst_n = 1'b1;
    run_op(3'd3, 8, dcyc, ndone);
    exp_r = rep(16'd6);
    total++; if (dcyc != 4 || ndone != 1) begin bad++; $display("FAIL rstmid_rerun cycle=%0d count=%0d exp cycle=4 count=1", dcyc, ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL rstmid_rerun_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  task automatic test_wrap();
    int dcyc, ndone, k;
    logic [PW-1:0] exp_r;
    in_poly[0] = rep(16'hFFFF);
    in_poly[1] = rep(16'h0001);
    run_op(3'd2, 6, dcyc, ndone);
    exp_r = rep(16'h0000);
    total++; if (dcyc != 3) begin bad++; $display("FAIL wrap_done_cycle got=%0d exp=3", dcyc); end
    total++; if (ndone != 1) begin bad++; $display("FAIL wrap_done_count got=%0d exp=1", ndone); end
    total++;
    if (bus.result !== exp_r) begin
      bad++; k = first_diff(bus.result, exp_r);
      $display("FAIL wrap_result coef[%0d] got=%h exp=%h", k, bus.result[k*16 +: 16], exp_r[k*16 +: 16]);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.num_ops = 3'd0; bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) in_poly[i] = '0;
    test_reset();
    test_sum5();
    test_single();
    test_err();
    test_ignore_abort();
    test_abort_idle();
    set_ramp();
    test_abort_done();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end
endmodule
